detect_event_counter: RTL and testbench
=======================================

Name: detect_event_counter

Overview:
- Downstream consumer of the sequence detector's z output (four-in-a-row 0s or 1s detector).
- Counts distinct detection events as a 2-digit BCD value (mod-100 built from chained mod-10 digits) and drives two 7-segment displays.
- Also measures how many cycles the last detection run held z high.
- Sits on the board between the detector's z and HEX1/HEX0; shares the detector's clock.

Parameters:
- RUN_W, 4, width of run-length counter; saturates at 2^RUN_W-1
- SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low (board default); 0 = active-high

Ports:
- Clock  input  1  system clock; all state updates on posedge
- Reset  input  1  asynchronous, active-high reset
- z_in  input  1  detector output z; level, synchronous to Clock
- clear  input  1  synchronous clear of counts, overflow and run length
- hold  input  1  freeze event count while high
- count_ones  output  4  BCD ones digit, 0..9
- count_tens  output  4  BCD tens digit, 0..9
- overflow  output  1  sticky; set on 99->00 wrap
- run_len  output  RUN_W  length in cycles of the last completed z-high run
- HEX0  output  7  segments for count_ones, bit0=a .. bit6=g
- HEX1  output  7  segments for count_tens

Behaviour:
- Reset (async, any time, including mid-run):
  - count_ones=0, count_tens=0, overflow=0, run_len=0.
  - Internal z_q=0, cur_run=0.
  - HEX0/HEX1 show "0": 7'b1000000 when SEG_ACTIVE_LOW=1.
- z_q: z_in registered every cycle, regardless of hold or clear. Event = z_in=1 and z_q=0 (rising edge) at a clock edge.
- Event count, applied at the same clock edge as the event; visible in the following cycle:
  - ones<9: ones+1.
  - ones=9: ones=0, tens+1.
  - tens=9 and ones=9: both become 0 and overflow is set to 1.
- hold=1: events are ignored, not deferred. z_q, cur_run and run_len keep updating.
- clear=1 at an edge:
  - counts=0, overflow=0, run_len=0, cur_run=0.
  - clear wins over a simultaneous event, wrap or run capture.
  - z_q still samples z_in. A z_in already high therefore produces no event until it falls and rises again.
- Run measurement, per edge when clear=0:
  - z_in=1, z_q=0: cur_run=1.
  - z_in=1, z_q=1: cur_run=min(cur_run+1, 2^RUN_W-1); saturates and does not wrap.
  - z_in=0, z_q=1: run_len=cur_run, cur_run=0.
  - Otherwise: hold values.
- A one-cycle z pulse gives run_len=1.
- Back-to-back runs (z falls for exactly one cycle) count as two events. run_len captures the first run at the fall.
- Segment decode: combinational from the registered digits; no added latency.
  - Active-high codes, gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Inverted when SEG_ACTIVE_LOW=1.
  - Digit codes 10..15 are unreachable; the decoder drives all segments off for them.
- overflow stays set through further counting until clear or Reset.

Test Plan:
- Reset asserted mid-count, with count=37 and z high for 3 cycles -> immediately count=00, overflow=0, run_len=0, HEX0=HEX1=7'b1000000; after release, z still high gives no event.
- Three z pulses of 1, 4 and 20 cycles (RUN_W=4), separated by 2 low cycles -> count=03; run_len=1, then 4, then 15 (saturated), each valid the cycle after the fall.
- 100 single-cycle pulses -> after the 99th: tens=9, ones=9, overflow=0; after the 100th: count=00, overflow=1; 5 more pulses -> count=05, overflow still 1.
- clear asserted on the same edge as a rising z, with count=09 -> count=00, no increment, tens stays 0; z falling later leaves run_len=0 or the partial run per the rules (check cur_run restarted at 0).
- hold=1 across 4 rising edges, then hold=0 with no new edge -> count unchanged; run_len still reports each run's length.
- Count 42, SEG_ACTIVE_LOW=1 -> HEX1=~7'h66=7'b0011001, HEX0=~7'h5B=7'b0100100; repeat with SEG_ACTIVE_LOW=0 -> 7'h66, 7'h5B.

Source files
------------

// File: rtl/detect_event_counter.sv
// -----------------------------------------------------------------------------
// detect_event_counter
//
// Counts rising edges of the sequence detector's z output as a two-digit BCD
// value (00..99, sticky overflow on wrap), measures how many cycles the last
// completed z-high run lasted, and drives two 7-segment displays.
//
// Parameters:
//   RUN_W          width of the run-length counter (saturates at 2^RUN_W-1)
//   SEG_ACTIVE_LOW 1 = segment outputs active-low, 0 = active-high
//
// Ports:
//   Clock       system clock, all state updates on posedge
//   Reset       asynchronous active-high reset
//   z_in        detector output (level, synchronous to Clock)
//   clear       synchronous clear of counts, overflow and run length
//   hold        ignore events while high (run measurement continues)
//   count_ones  BCD ones digit
//   count_tens  BCD tens digit
//   overflow    sticky flag, set on 99 -> 00
//   run_len     length in cycles of the last completed z-high run
//   HEX0        segments for count_ones, bit0=a .. bit6=g
//   HEX1        segments for count_tens
// -----------------------------------------------------------------------------
module detect_event_counter #(
    parameter int RUN_W          = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             z_in,
    input  logic             clear,
    input  logic             hold,
    output logic [3:0]       count_ones,
    output logic [3:0]       count_tens,
    output logic             overflow,
    output logic [RUN_W-1:0] run_len,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic             z_q;
    logic [3:0]       ones_reg, ones_next;
    logic [3:0]       tens_reg, tens_next;
    logic             ovf_reg, ovf_next;
    logic [RUN_W-1:0] cur_run_reg, cur_run_next;
    logic [RUN_W-1:0] run_len_reg, run_len_next;
    logic             rise;

    assign rise = z_in & ~z_q;

    always_comb begin
        ones_next    = ones_reg;
        tens_next    = tens_reg;
        ovf_next     = ovf_reg;
        cur_run_next = cur_run_reg;
        run_len_next = run_len_reg;

        if (clear) begin
            // clear takes priority over any event, wrap or run capture
            ones_next    = 4'd0;
            tens_next    = 4'd0;
            ovf_next     = 1'b0;
            cur_run_next = '0;
            run_len_next = '0;
        end else begin
            // events arriving under hold are dropped, not queued
            if (rise && !hold) begin
                if (ones_reg == 4'd9) begin
                    ones_next = 4'd0;
                    if (tens_reg == 4'd9) begin
                        tens_next = 4'd0;
                        ovf_next  = 1'b1;
                    end else begin
                        tens_next = tens_reg + 4'd1;
                    end
                end else begin
                    ones_next = ones_reg + 4'd1;
                end
            end

            if (z_in && !z_q) begin
                cur_run_next = RUN_W'(1);
            end else if (z_in && z_q) begin
                // saturate rather than wrap so long runs read as "at least max"
                if (cur_run_reg != RUN_MAX)
                    cur_run_next = cur_run_reg + RUN_W'(1);
            end else if (!z_in && z_q) begin
                run_len_next = cur_run_reg;
                cur_run_next = '0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            z_q         <= 1'b0;
            ones_reg    <= 4'd0;
            tens_reg    <= 4'd0;
            ovf_reg     <= 1'b0;
            cur_run_reg <= '0;
            run_len_reg <= '0;
        end else begin
            // z_q tracks z_in unconditionally, so a level already high at
            // clear produces no event until it falls and rises again
            z_q         <= z_in;
            ones_reg    <= ones_next;
            tens_reg    <= tens_next;
            ovf_reg     <= ovf_next;
            cur_run_reg <= cur_run_next;
            run_len_reg <= run_len_next;
        end
    end

    assign count_ones = ones_reg;
    assign count_tens = tens_reg;
    assign overflow   = ovf_reg;
    assign run_len    = run_len_reg;

    // Seven-segment decode, gfedcba active-high; digits 10..15 blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [3:0] digit [2];
    logic [6:0] seg   [2];

    assign digit[0] = ones_reg;
    assign digit[1] = tens_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_seg
            if (SEG_ACTIVE_LOW) begin : g_low
                assign seg[gi] = ~seg_decode(digit[gi]);
            end else begin : g_high
                assign seg[gi] = seg_decode(digit[gi]);
            end
        end
    endgenerate

    assign HEX0 = seg[0];
    assign HEX1 = seg[1];

endmodule

// File: tb/tb_detect_event_counter.sv
module tb_detect_event_counter;

    logic       clk;
    logic       rst;
    logic       z_in;
    logic       clear;
    logic       hold;
    logic [3:0] count_ones, count_tens;
    logic       overflow;
    logic [3:0] run_len;
    logic [6:0] hex0, hex1;
    logic [3:0] h_ones, h_tens;
    logic       h_ovf;
    logic [3:0] h_run_len;
    logic [6:0] h_hex0, h_hex1;

    int n_cmp = 0;
    int n_err = 0;

    detect_event_counter #(.RUN_W(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .Clock(clk), .Reset(rst), .z_in(z_in), .clear(clear), .hold(hold),
        .count_ones(count_ones), .count_tens(count_tens), .overflow(overflow),
        .run_len(run_len), .HEX0(hex0), .HEX1(hex1)
    );

    detect_event_counter #(.RUN_W(4), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .Clock(clk), .Reset(rst), .z_in(z_in), .clear(clear), .hold(hold),
        .count_ones(h_ones), .count_tens(h_tens), .overflow(h_ovf),
        .run_len(h_run_len), .HEX0(h_hex0), .HEX1(h_hex1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic clr;
        logic hld;
        logic z;
        int   n;
        int   ones;
        int   tens;
        int   ovf;
        int   rl;
    } vec_t;

    vec_t tbl[$];

    function automatic int seg_hi(input int d);
        case (d)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            7: return 'h07;
            8: return 'h7F;
            9: return 'h6F;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Inputs change at posedge+1; outputs sampled at posedge+1 after n edges.
    task automatic step(input logic c, input logic h, input logic z, input int n);
        clear = c;
        hold  = h;
        z_in  = z;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        step(1'b0, 1'b0, 1'b1, 1);
        step(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic chk_count(input string nm, input int o, input int t, input int ov);
        chk({nm, ".ones"}, int'(count_ones), o);
        chk({nm, ".tens"}, int'(count_tens), t);
        chk({nm, ".ovf"},  int'(overflow),   ov);
    endtask

    initial begin
        // clr hld z  n  ones tens ovf run_len
        tbl.push_back('{1'b0, 1'b0, 1'b0,  2, 0, 0, 0,  0});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 1, 0, 0,  0});  // 1-cycle pulse
        tbl.push_back('{1'b0, 1'b0, 1'b0,  2, 1, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  4, 2, 0, 0,  1});  // 4-cycle pulse
        tbl.push_back('{1'b0, 1'b0, 1'b0,  2, 2, 0, 0,  4});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 20, 3, 0, 0,  4});  // 20-cycle pulse
        tbl.push_back('{1'b0, 1'b0, 1'b0,  2, 3, 0, 0, 15});  // saturated
        tbl.push_back('{1'b0, 1'b1, 1'b1,  2, 3, 0, 0, 15});  // hold: edge 1
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 3, 0, 0,  2});
        tbl.push_back('{1'b0, 1'b1, 1'b1,  1, 3, 0, 0,  2});  // edge 2
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 3, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b1, 1'b1,  3, 3, 0, 0,  1});  // edge 3
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 3, 0, 0,  3});
        tbl.push_back('{1'b0, 1'b1, 1'b1,  5, 3, 0, 0,  3});  // edge 4
        tbl.push_back('{1'b0, 1'b1, 1'b0,  1, 3, 0, 0,  5});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  2, 3, 0, 0,  5});  // hold off, no edge
        tbl.push_back('{1'b0, 1'b0, 1'b1,  3, 4, 0, 0,  5});  // back-to-back run A
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 4, 0, 0,  3});  // single low cycle
        tbl.push_back('{1'b0, 1'b0, 1'b1,  2, 5, 0, 0,  3});  // run B
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 5, 0, 0,  2});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 6, 0, 0,  2});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 6, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 7, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 7, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 8, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 8, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b1,  1, 9, 0, 0,  1});
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 9, 0, 0,  1});  // count 09
        tbl.push_back('{1'b1, 1'b0, 1'b1,  1, 0, 0, 0,  0});  // clear beats rise
        tbl.push_back('{1'b0, 1'b0, 1'b1,  2, 0, 0, 0,  0});  // no event, run restarts
        tbl.push_back('{1'b0, 1'b0, 1'b0,  1, 0, 0, 0,  2});  // partial run only

        rst   = 1'b1;
        z_in  = 1'b0;
        clear = 1'b0;
        hold  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_count("reset", 0, 0, 0);
        chk("reset.run_len", int'(run_len), 0);
        chk("reset.hex0", int'(hex0), 'b1000000);
        chk("reset.hex1", int'(hex1), 'b1000000);
        chk("reset.hi_hex0", int'(h_hex0), 'h3F);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].hld, tbl[i].z, tbl[i].n);
            $display("vec %0d: clr=%0b hold=%0b z=%0b x%0d -> tens=%0d ones=%0d ovf=%0b run_len=%0d",
                     i, tbl[i].clr, tbl[i].hld, tbl[i].z, tbl[i].n,
                     count_tens, count_ones, overflow, run_len);
            chk_count($sformatf("vec%0d", i), tbl[i].ones, tbl[i].tens, tbl[i].ovf);
            chk($sformatf("vec%0d.run_len", i), int'(run_len), tbl[i].rl);
            chk($sformatf("vec%0d.hex0", i), int'(hex0), (~seg_hi(tbl[i].ones)) & 'h7F);
            chk($sformatf("vec%0d.hex1", i), int'(hex1), (~seg_hi(tbl[i].tens)) & 'h7F);
        end

        // 99 pulses from 00, checking each digit and its active-low segments.
        for (int k = 1; k <= 99; k++) begin
            pulse();
            chk($sformatf("cnt%0d.ones", k), int'(count_ones), k % 10);
            chk($sformatf("cnt%0d.tens", k), int'(count_tens), k / 10);
            chk($sformatf("cnt%0d.hex0", k), int'(hex0), (~seg_hi(k % 10)) & 'h7F);
            chk($sformatf("cnt%0d.hex1", k), int'(hex1), (~seg_hi(k / 10)) & 'h7F);
        end
        chk_count("at99", 9, 9, 0);
        pulse();
        chk_count("wrap100", 0, 0, 1);
        chk("wrap100.run_len", int'(run_len), 1);
        repeat (5) pulse();
        chk_count("after105", 5, 0, 1);
        step(1'b1, 1'b0, 1'b0, 1);
        chk_count("clear_ovf", 0, 0, 0);
        chk("clear_ovf.run_len", int'(run_len), 0);

        // Count 42 on both segment polarities.
        repeat (42) pulse();
        chk_count("c42", 2, 4, 0);
        chk("c42.hex1_low", int'(hex1), 'b0011001);
        chk("c42.hex0_low", int'(hex0), 'b0100100);
        chk("c42.hex1_high", int'(h_hex1), 'h66);
        chk("c42.hex0_high", int'(h_hex0), 'h5B);
        step(1'b1, 1'b0, 1'b0, 1);

        // Asynchronous reset mid-count while z is high.
        repeat (37) pulse();
        chk_count("c37", 7, 3, 0);
        step(1'b0, 1'b0, 1'b1, 3);
        chk_count("c38_zhigh", 8, 3, 0);
        chk("c38_zhigh.run_len", int'(run_len), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_count("async_rst", 0, 0, 0);
        chk("async_rst.run_len", int'(run_len), 0);
        chk("async_rst.hex0", int'(hex0), 'b1000000);
        chk("async_rst.hex1", int'(hex1), 'b1000000);
        chk("async_rst.hi_hex1", int'(h_hex1), 'h3F);
        repeat (2) @(posedge clk);
        #1;
        chk_count("rst_held_zhigh", 0, 0, 0);
        z_in = 1'b0;
        rst  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 2);
        chk_count("post_rst", 0, 0, 0);
        chk("post_rst.run_len", int'(run_len), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
